// File: rtl/avlnst_pkt_rr_arb.sv
// Packet-level round-robin arbiter merging NUM_REQ Avalon-ST streams; grant held sof..eof.
// Latency: one arbitration cycle per packet, then an accepted beat appears on o_* next cycle.
// Backpressure: o_rdy only to the granted requester when the output register can load.
// Optional framing checker: define AVLNST_PKT_RR_ARB_CHECK_EN (adds o_err/o_err_cnt).
module avlnst_pkt_rr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]            i_vld,
    input  logic [NUM_REQ-1:0]            i_sof,
    input  logic [NUM_REQ-1:0]            i_eof,
    output logic [NUM_REQ-1:0]            o_rdy,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_vld,
    output logic                          o_sof,
    output logic                          o_eof,
    input  logic                          i_rdy,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
    ,
    output logic                          o_err,
    output logic [15:0]                   o_err_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, GNT = 1'b1} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_vld;
    logic                    load_ok;
    logic                    acc;
    logic                    beat_sof;
    logic                    beat_eof;
    logic                    out_sof;
    logic                    drop;
    logic [DATA_WIDTH-1:0]   beat_dat;

    assign load_ok  = !o_vld || i_rdy;
    assign o_rdy    = (state_q == GNT && load_ok) ? o_grant : '0;
    assign acc      = |(i_vld & o_rdy);
    assign beat_sof = |(i_sof & o_grant);
    assign beat_eof = |(i_eof & o_grant);

    // grant is one-hot, so an OR of masked lanes is the data mux
    always_comb begin
        beat_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) begin
                beat_dat = beat_dat | i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // walk downward so the candidate closest to ptr_q wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (i_vld[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
    logic first_q;
    logic sof_bad;

    assign drop    = first_q && !beat_sof;
    assign sof_bad = !first_q && beat_sof;
    assign out_sof = first_q && beat_sof;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            first_q   <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                first_q <= 1'b1;
            end else if (acc) begin
                first_q <= 1'b0;
            end
            if (acc && (drop || sof_bad)) begin
                o_err <= 1'b1;
                if (o_err_cnt != 16'hFFFF) begin
                    o_err_cnt <= o_err_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign drop    = 1'b0;
    assign out_sof = beat_sof;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            o_grant <= '0;
            o_busy  <= 1'b0;
            o_vld   <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_data  <= '0;
        end else begin
            if (acc && !drop) begin
                o_vld  <= 1'b1;
                o_data <= beat_dat;
                o_sof  <= out_sof;
                o_eof  <= beat_eof;
            end else if (i_rdy) begin
                o_vld  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        o_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        idx_q   <= pick_idx;
                        o_busy  <= 1'b1;
                        state_q <= GNT;
                    end
                end
                GNT: begin
                    // release on the accepted eof even if downstream stalls it
                    if (acc && beat_eof) begin
                        o_grant <= '0;
                        ptr_q   <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                        o_busy  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avlnst_pkt_rr_arb.sv
// Bench for avlnst_pkt_rr_arb: directed plan items plus randomized traffic against a
// packet-level scoreboard and a round-robin reference.
module tb_avlnst_pkt_rr_arb;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_vld, i_sof, i_eof;
    logic [N-1:0]    o_rdy;
    logic [DW-1:0]   o_data;
    logic            o_vld, o_sof, o_eof;
    logic            i_rdy;
    logic [N-1:0]    o_grant;
    logic            o_busy;
`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
    logic            o_err;
    logic [15:0]     o_err_cnt;
`endif

    always #5 i_clk = ~i_clk;

    avlnst_pkt_rr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_vld   (i_vld),
        .i_sof   (i_sof),
        .i_eof   (i_eof),
        .o_rdy   (o_rdy),
        .o_data  (o_data),
        .o_vld   (o_vld),
        .o_sof   (o_sof),
        .o_eof   (o_eof),
        .i_rdy   (i_rdy),
        .o_grant (o_grant),
        .o_busy  (o_busy)
`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
        ,
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
`endif
    );

    typedef struct packed {logic [63:0] d; logic sof; logic eof;} beat_t;
    typedef struct packed {logic [1:0] src; logic [63:0] d; logic sof; logic eof;} exp_t;

    beat_t        src_q [N][$];
    exp_t         exp_q [$];
    logic [63:0]  dat_log [$];
    int           pkt_log [$];
    logic [N-1:0] gnt_log [$];
    int           rdy_pat [$];
    logic [N-1:0] pres = '0;

    int           n_chk = 0;
    int           n_err = 0;
    int           ptr_m = 0;
    bit           in_pkt = 1'b0;
    int           cur_src = 0;
    bit           lat_pend = 1'b0;
    exp_t         lat_b;
    bit           hold_prev = 1'b0;
    logic [66:0]  prev_out;
    bit           arb_pend = 1'b0;
    logic [N-1:0] exp_gnt;
    bit           gap_en = 1'b0;
    bit           rnd_rdy = 1'b0;
    int           hold_cnt = 0;
    int           acc_cnt [N];
    int           err_m = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // first requester at or after ptr, wrapping
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int ptr);
        for (int d = 0; d < N; d++) begin
            if (req[(ptr + d) % N]) return N'(1) << ((ptr + d) % N);
        end
        return '0;
    endfunction

    task automatic push_beat(input int k, input logic [63:0] d, input logic sof, input logic eof);
        beat_t b;
        b.d = d; b.sof = sof; b.eof = eof;
        src_q[k].push_back(b);
    endtask

    task automatic push_pkt(input int k, input int len, input logic [63:0] base);
        for (int i = 0; i < len; i++) push_beat(k, base + 64'(i), i == 0, i == len - 1);
    endtask

    task automatic step();
        logic [N-1:0] acc;
        beat_t        b;
        exp_t         e;
        bit           first;
        @(negedge i_clk);
        acc = i_vld & o_rdy;
        chk("rdy", 64'(o_rdy), 64'((o_busy && (!o_vld || i_rdy)) ? o_grant : 4'b0));
        chk("busy", 64'(o_busy), 64'(o_grant != 0));
        chk("gnt_onehot", 64'($countones(o_grant) <= 1), 64'(1));
        chk("acc_onehot", 64'($countones(acc) <= 1), 64'(1));
`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
        chk("err_cnt", 64'(o_err_cnt), 64'(err_m));
        chk("err", 64'(o_err), 64'(err_m != 0));
`endif
        if (hold_prev) begin
            hold_cnt++;
            chk("hold_flags", 64'({o_vld, o_sof, o_eof}), 64'(prev_out[66:64]));
            chk("hold_dat", o_data, prev_out[63:0]);
        end
        if (lat_pend) begin
            chk("lat_vld", 64'(o_vld), 64'(1));
            chk("lat_dat", o_data, lat_b.d);
            chk("lat_flags", 64'({o_sof, o_eof}), 64'({lat_b.sof, lat_b.eof}));
        end
        if (o_vld && i_rdy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_dat", o_data, e.d);
                chk("out_flags", 64'({o_sof, o_eof}), 64'({e.sof, e.eof}));
                dat_log.push_back(o_data);
                if (e.sof) pkt_log.push_back(int'(e.src));
            end
        end
        if (arb_pend) begin
            chk("grant", 64'(o_grant), 64'(exp_gnt));
            gnt_log.push_back(o_grant);
            arb_pend = 1'b0;
        end
        if (!o_busy && i_vld != 0) begin
            arb_pend = 1'b1;
            exp_gnt  = rr_pick(i_vld, ptr_m);
        end
        lat_pend = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                b = src_q[k][0];
                acc_cnt[k]++;
                if (in_pkt) chk("no_interleave", 64'(k), 64'(cur_src));
                first = !in_pkt;
                e.src = 2'(k); e.d = b.d; e.sof = b.sof; e.eof = b.eof;
`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
                if (first && !b.sof) begin
                    err_m++;
                end else begin
                    if (!first && b.sof) begin
                        err_m++;
                        e.sof = 1'b0;
                    end
                    exp_q.push_back(e);
                    lat_pend = 1'b1;
                    lat_b    = e;
                end
`else
                if (first) e.sof = b.sof;
                exp_q.push_back(e);
                lat_pend = 1'b1;
                lat_b    = e;
`endif
                if (b.eof) begin
                    in_pkt = 1'b0;
                    ptr_m  = (k + 1) % N;
                end else begin
                    in_pkt  = 1'b1;
                    cur_src = k;
                end
            end
        end
        hold_prev = o_vld && !i_rdy;
        prev_out  = {o_vld, o_sof, o_eof, o_data};

        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                void'(src_q[k].pop_front());
                pres[k] = 1'b0;
            end
            if (!pres[k] && src_q[k].size() > 0 && (!gap_en || $urandom_range(3) != 0)) pres[k] = 1'b1;
            i_vld[k] = pres[k];
            if (pres[k]) begin
                i_data[k*DW +: DW] = src_q[k][0].d;
                i_sof[k] = src_q[k][0].sof;
                i_eof[k] = src_q[k][0].eof;
            end else begin
                i_sof[k] = 1'b0;
                i_eof[k] = 1'b0;
            end
        end
        if (rdy_pat.size() > 0)  i_rdy = (rdy_pat.pop_front() != 0);
        else if (rnd_rdy)        i_rdy = ($urandom_range(9) < 7);
        else                     i_rdy = 1'b1;
    endtask

    function automatic bit any_pend();
        for (int k = 0; k < N; k++) if (src_q[k].size() > 0) return 1'b1;
        return exp_q.size() > 0 || o_vld || o_busy;
    endfunction

    task automatic drain(input int budget);
        int c = 0;
        while (any_pend() && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) chk("drain_timeout", 64'(1), 64'(0));
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        rdy_pat.delete();
        pres = '0; i_vld = '0; i_sof = '0; i_eof = '0;
        ptr_m = 0; in_pkt = 1'b0; lat_pend = 1'b0; hold_prev = 1'b0; arb_pend = 1'b0; err_m = 0;
    endtask

    initial begin
        int c;
        i_data = '0; i_vld = '0; i_sof = '0; i_eof = '0; i_rdy = 1'b1;
        for (int k = 0; k < N; k++) acc_cnt[k] = 0;
        #12;
        chk("rst_vld", 64'(o_vld), 64'(0));
        chk("rst_sof", 64'(o_sof), 64'(0));
        chk("rst_eof", 64'(o_eof), 64'(0));
        chk("rst_dat", o_data, 64'(0));
        chk("rst_gnt", 64'(o_grant), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_rdy", 64'(o_rdy), 64'(0));
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;

        // single requester, 4-beat packet
        gnt_log.delete(); dat_log.delete();
        push_pkt(1, 4, 64'h10);
        drain(50);
        chk("t1_beats", 64'(dat_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("t1_dat", (i < dat_log.size()) ? dat_log[i] : '1, 64'h10 + 64'(i));
        chk("t1_gnt", 64'((gnt_log.size() > 0) ? gnt_log[0] : 4'b0), 64'(4'b0010));

        // bring pointer to 0, then all four request continuously
        push_pkt(3, 1, 64'h30);
        drain(50);
        pkt_log.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push_pkt(k, 2, 64'h100 * 64'(k) + 64'h10 * 64'(r));
        drain(200);
        chk("rr_pkts", 64'(pkt_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("rr_order", 64'((i < pkt_log.size()) ? pkt_log[i] : -1), 64'(i % N));

        // pointer to 1, then simultaneous single-beat packets from 0 and 3
        push_pkt(0, 1, 64'h40);
        drain(50);
        gnt_log.delete();
        push_pkt(0, 1, 64'hA0);
        push_pkt(3, 1, 64'hA3);
        drain(50);
        chk("sb_ngnt", 64'(gnt_log.size()), 64'(2));
        chk("sb_gnt0", 64'((gnt_log.size() > 0) ? gnt_log[0] : 4'b0), 64'(4'b1000));
        chk("sb_gnt1", 64'((gnt_log.size() > 1) ? gnt_log[1] : 4'b0), 64'(4'b0001));

        // downstream backpressure during a 3-beat packet from req2
        dat_log.delete(); hold_cnt = 0;
        rdy_pat = '{1, 1, 0, 0, 1, 1, 0, 1};
        push_pkt(2, 3, 64'h20);
        drain(50);
        chk("bp_beats", 64'(dat_log.size()), 64'(3));
        for (int i = 0; i < 3; i++) chk("bp_dat", (i < dat_log.size()) ? dat_log[i] : '1, 64'h20 + 64'(i));
        chk("bp_stall_seen", 64'(hold_cnt > 0), 64'(1));

        // async reset during beat 2 of a 5-beat packet
        push_pkt(1, 5, 64'h50);
        acc_cnt[1] = 0; c = 0;
        while (acc_cnt[1] < 2 && c < 50) begin
            step();
            c++;
        end
        if (c >= 50) chk("rst_wait_timeout", 64'(1), 64'(0));
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(o_vld), 64'(0));
        chk("arst_gnt", 64'(o_grant), 64'(0));
        chk("arst_busy", 64'(o_busy), 64'(0));
        model_reset();
        step();
        step();
        #2 i_rst_n = 1'b1;
        gnt_log.delete();
        push_pkt(3, 1, 64'h63);
        push_pkt(1, 1, 64'h61);
        drain(50);
        chk("post_rst_gnt0", 64'((gnt_log.size() > 0) ? gnt_log[0] : 4'b0), 64'(4'b0010));
        chk("post_rst_gnt1", 64'((gnt_log.size() > 1) ? gnt_log[1] : 4'b0), 64'(4'b1000));

        // randomized traffic with source bubbles and random downstream ready
        gap_en = 1'b1; rnd_rdy = 1'b1;
        for (int k = 0; k < N; k++)
            for (int p = 0; p < 8; p++) push_pkt(k, $urandom_range(1, 4), {32'(k), $urandom});
        drain(3000);
        gap_en = 1'b0; rnd_rdy = 1'b0;

`ifdef AVLNST_PKT_RR_ARB_CHECK_EN
        dat_log.delete();
        push_beat(0, 64'hE0, 1'b0, 1'b0);
        push_beat(0, 64'hE1, 1'b0, 1'b1);
        drain(50);
        chk("ck_drop_cnt", 64'(o_err_cnt), 64'(1));
        chk("ck_drop_err", 64'(o_err), 64'(1));
        push_beat(0, 64'hF0, 1'b1, 1'b0);
        push_beat(0, 64'hF1, 1'b1, 1'b0);
        push_beat(0, 64'hF2, 1'b0, 1'b1);
        drain(50);
        chk("ck_mid_cnt", 64'(o_err_cnt), 64'(2));
        chk("ck_beats", 64'(dat_log.size()), 64'(4));
        chk("ck_first", (dat_log.size() > 0) ? dat_log[0] : '1, 64'hE1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
